// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source ids and the CDB entry payload for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned NSRC   = 3;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ROB_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SRC_W  = 2;

  typedef enum logic [SRC_W-1:0] {
    SRC_ALU = 2'd0,
    SRC_LSB = 2'd1,
    SRC_BR  = 2'd2
  } src_id_e;

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] aux;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_src_queue.sv
// Per-source result FIFO: DEPTH entries, naturally wrapping pointers, flush empties it.
module cdb_src_queue
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  cdb_entry_t wdata_i,
  output logic       full_c,
  output logic       empty_c,
  output cdb_entry_t head_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;
  cdb_entry_t       mem_q [DEPTH];

  assign full_c  = (cnt_q == CNT_W'(DEPTH));
  assign empty_c = (cnt_q == '0);
  assign head_c  = mem_q[head_q];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push_i & ~full_c & ~flush_i;
  assign pop_ok  = pop_i & ~empty_c & ~flush_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) tail_d = tail_q + PTR_W'(1);
      if (pop_ok)  head_d = head_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: it is only read while the count says non-empty.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[tail_q] <= wdata_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that drains per-source result queues onto one registered CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*ROB_W-1:0]  src_rob,
  input  logic [NSRC*DATA_W-1:0] src_value,
  input  logic [NSRC*DATA_W-1:0] src_aux,
  output logic [NSRC-1:0]        src_ready,
  output logic                   cdb_valid,
  output logic [ROB_W-1:0]       cdb_rob,
  output logic [DATA_W-1:0]      cdb_value,
  output logic [DATA_W-1:0]      cdb_aux,
  output logic [SRC_W-1:0]       cdb_src
);

  logic [NSRC-1:0]  full, empty, push, pop;
  cdb_entry_t       wdata [NSRC];
  cdb_entry_t       head  [NSRC];

  logic             gnt_found_c;
  logic [SRC_W-1:0] gnt_idx_c;

  logic             valid_q, valid_d;
  cdb_entry_t       out_q, out_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [SRC_W-1:0] rr_q, rr_d;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign wdata[i]     = {src_rob[i*ROB_W +: ROB_W], src_value[i*DATA_W +: DATA_W],
                           src_aux[i*DATA_W +: DATA_W]};
    assign src_ready[i] = ~full[i];
    assign push[i]      = rdy_in & ~flush_in & src_valid[i] & ~full[i];
    assign pop[i]       = rdy_in & ~flush_in & gnt_found_c & (gnt_idx_c == SRC_W'(i));

    cdb_src_queue #(.DEPTH(DEPTH)) u_queue (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .flush_i (flush_in),
      .wdata_i (wdata[i]),
      .full_c  (full[i]),
      .empty_c (empty[i]),
      .head_c  (head[i])
    );
  end

  // First non-empty queue found scanning from rr_q, wrapping modulo NSRC.
  always_comb begin
    logic [SRC_W-1:0] idx;
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      idx = SRC_W'((32'(rr_q) + k) % NSRC);
      if (!gnt_found_c && !empty[idx]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = idx;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    src_d   = src_q;
    rr_d    = rr_q;
    if (flush_in) begin
      valid_d = 1'b0;
      rr_d    = SRC_ALU;
    end else if (rdy_in) begin
      if (gnt_found_c) begin
        valid_d = 1'b1;
        out_d   = head[gnt_idx_c];
        src_d   = gnt_idx_c;
        rr_d    = (gnt_idx_c == SRC_W'(NSRC - 1)) ? SRC_ALU : gnt_idx_c + SRC_W'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      src_q   <= SRC_ALU;
      rr_q    <= SRC_ALU;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_rob   = out_q.rob;
  assign cdb_value = out_q.value;
  assign cdb_aux   = out_q.aux;
  assign cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter with hand-computed per-cycle expectations.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic                   rdy_in;
  logic                   flush_in;
  logic [NSRC-1:0]        src_valid;
  logic [NSRC*ROB_W-1:0]  src_rob;
  logic [NSRC*DATA_W-1:0] src_value;
  logic [NSRC*DATA_W-1:0] src_aux;
  logic [NSRC-1:0]        src_ready;
  logic                   cdb_valid;
  logic [ROB_W-1:0]       cdb_rob;
  logic [DATA_W-1:0]      cdb_value;
  logic [DATA_W-1:0]      cdb_aux;
  logic [SRC_W-1:0]       cdb_src;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .src_valid (src_valid),
    .src_rob   (src_rob),
    .src_value (src_value),
    .src_aux   (src_aux),
    .src_ready (src_ready),
    .cdb_valid (cdb_valid),
    .cdb_rob   (cdb_rob),
    .cdb_value (cdb_value),
    .cdb_aux   (cdb_aux),
    .cdb_src   (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       rdy;
    logic       flush;
    logic [2:0] valid;
    logic [3:0] r0, r1, r2;
    logic       exp_valid;
    logic [3:0] exp_rob;
    logic [1:0] exp_src;
    logic [2:0] exp_ready;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rdy, input logic flush, input logic [2:0] valid,
                              input int r0, input int r1, input int r2,
                              input logic ev, input int erob, input int esrc,
                              input logic [2:0] erdy);
    vec_t v;
    v.rdy = rdy; v.flush = flush; v.valid = valid;
    v.r0 = 4'(r0); v.r1 = 4'(r1); v.r2 = 4'(r2);
    v.exp_valid = ev; v.exp_rob = 4'(erob); v.exp_src = 2'(esrc); v.exp_ready = erdy;
    return v;
  endfunction

  // Value/aux words are derived from the tag so the broadcast payload can be predicted.
  function automatic logic [31:0] pat_val(input logic [3:0] r);
    return (r == 4'd0) ? 32'd0 : {28'hC0FFEE0, r};
  endfunction
  function automatic logic [31:0] pat_aux(input logic [3:0] r);
    return (r == 4'd0) ? 32'd0 : {28'hA55A000, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic flush, input logic [2:0] valid,
                       input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
    rdy_in    = rdy;
    flush_in  = flush;
    src_valid = valid;
    src_rob   = {r2, r1, r0};
    src_value = {pat_val(r2), pat_val(r1), pat_val(r0)};
    src_aux   = {pat_aux(r2), pat_aux(r1), pat_aux(r0)};
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [3:0] erob,
                         input logic [31:0] eval, input logic [31:0] eaux,
                         input logic [1:0] esrc, input logic [2:0] erdy);
    chk({tag, " cdb_valid"}, 32'(cdb_valid), 32'(ev));
    chk({tag, " cdb_rob"},   32'(cdb_rob),   32'(erob));
    chk({tag, " cdb_value"}, cdb_value,      eval);
    chk({tag, " cdb_aux"},   cdb_aux,        eaux);
    chk({tag, " cdb_src"},   32'(cdb_src),   32'(esrc));
    chk({tag, " src_ready"}, 32'(src_ready), 32'(erdy));
  endtask

  initial begin
    logic [2:0] prev_ready;

    // all three push, two waves, then drain
    vecs[0]  = mk(1, 0, 3'b111, 1, 2, 3,    0, 0, 0, 3'b111);
    vecs[1]  = mk(1, 0, 3'b111, 4, 5, 6,    1, 1, 0, 3'b001);
    vecs[2]  = mk(1, 0, 3'b000, 0, 0, 0,    1, 2, 1, 3'b011);
    vecs[3]  = mk(1, 0, 3'b000, 0, 0, 0,    1, 3, 2, 3'b111);
    vecs[4]  = mk(1, 0, 3'b000, 0, 0, 0,    1, 4, 0, 3'b111);
    vecs[5]  = mk(1, 0, 3'b000, 0, 0, 0,    1, 5, 1, 3'b111);
    vecs[6]  = mk(1, 0, 3'b000, 0, 0, 0,    1, 6, 2, 3'b111);
    vecs[7]  = mk(1, 0, 3'b000, 0, 0, 0,    0, 6, 2, 3'b111);
    // ALU fills while others are served; row 11 pushes into a full ALU queue
    vecs[8]  = mk(1, 0, 3'b110, 0, 7, 8,    0, 6, 2, 3'b111);
    vecs[9]  = mk(1, 0, 3'b001, 9, 0, 0,    1, 7, 1, 3'b111);
    vecs[10] = mk(1, 0, 3'b001, 10, 0, 0,   1, 8, 2, 3'b110);
    vecs[11] = mk(1, 0, 3'b001, 11, 0, 0,   1, 9, 0, 3'b111);
    vecs[12] = mk(1, 0, 3'b000, 0, 0, 0,    1, 10, 0, 3'b111);
    vecs[13] = mk(1, 0, 3'b000, 0, 0, 0,    0, 10, 0, 3'b111);
    // four pending entries, then a flush with a concurrent push
    vecs[14] = mk(1, 0, 3'b111, 1, 2, 3,    0, 10, 0, 3'b111);
    vecs[15] = mk(1, 0, 3'b101, 4, 0, 5,    1, 2, 1, 3'b010);
    vecs[16] = mk(1, 1, 3'b111, 12, 13, 14, 0, 2, 1, 3'b111);
    vecs[17] = mk(1, 0, 3'b000, 0, 0, 0,    0, 2, 1, 3'b111);
    // stall with rdy_in low for five cycles
    vecs[18] = mk(1, 0, 3'b111, 1, 2, 3,    0, 2, 1, 3'b111);
    vecs[19] = mk(1, 0, 3'b000, 0, 0, 0,    1, 1, 0, 3'b111);
    for (int i = 20; i < 25; i++) vecs[i] = mk(0, 0, 3'b111, 7, 8, 9, 1, 1, 0, 3'b111);
    vecs[25] = mk(1, 0, 3'b000, 0, 0, 0,    1, 2, 1, 3'b111);
    vecs[26] = mk(1, 0, 3'b000, 0, 0, 0,    1, 3, 2, 3'b111);
    vecs[27] = mk(1, 0, 3'b000, 0, 0, 0,    0, 3, 2, 3'b111);

    rst_in = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);
    #1;
    chk_out("reset", 1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 3'b111);

    // single ALU push: broadcast in the cycle after the second edge
    @(negedge clk_in);
    rst_in = 1'b1;
    drive(1'b1, 1'b0, 3'b001, 4'd3, 4'd0, 4'd0);
    src_value[31:0] = 32'h11;
    src_aux[31:0]   = 32'h0;
    @(posedge clk_in); #1;
    chk_out("single e1", 1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 3'b111);
    @(negedge clk_in);
    drive(1'b1, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);
    @(posedge clk_in); #1;
    chk_out("single e2", 1'b1, 4'd3, 32'h11, 32'h0, 2'd0, 3'b111);
    @(posedge clk_in); #1;
    chk_out("single e3", 1'b0, 4'd3, 32'h11, 32'h0, 2'd0, 3'b111);

    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk_out("re-reset", 1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 3'b111);
    #2 rst_in = 1'b1;

    prev_ready = 3'b111;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_in);
      drive(vecs[i].rdy, vecs[i].flush, vecs[i].valid, vecs[i].r0, vecs[i].r1, vecs[i].r2);
      #1;
      chk($sformatf("row%0d pre src_ready", i), 32'(src_ready), 32'(prev_ready));
      if ((src_valid & ~src_ready) != 3'b000)
        $display("NOTE row%0d: protocol violation, src_valid=%b while src_ready=%b (push dropped)",
                 i, src_valid, src_ready);
      @(posedge clk_in); #1;
      chk_out($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_rob,
              pat_val(vecs[i].exp_rob), pat_aux(vecs[i].exp_rob),
              vecs[i].exp_src, vecs[i].exp_ready);
      prev_ready = vecs[i].exp_ready;
    end

    // async reset between edges with entries pending and cdb_valid high
    @(negedge clk_in);
    drive(1'b1, 1'b0, 3'b111, 4'd1, 4'd2, 4'd3);
    @(negedge clk_in);
    drive(1'b1, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);
    @(posedge clk_in); #1;
    chk_out("prerst", 1'b1, 4'd1, pat_val(4'd1), pat_aux(4'd1), 2'd0, 3'b111);
    #2 rst_in = 1'b0;
    #1;
    chk_out("async rst", 1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 3'b111);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk_out("post rst e1", 1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 3'b111);
    @(posedge clk_in); #1;
    chk_out("post rst e2", 1'b0, 4'd0, 32'd0, 32'd0, 2'd0, 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NSRC execution units: ALU, LSB load path and branch unit.
- The CDB carries results back to the ROB, RS, LSB and the Regfile snoop paths.
- Each source pushes completed results into a private small queue. A round-robin scheduler grants one queue head per cycle onto a registered CDB.
- A ROB-issued flush on mispredict discards all pending results.

Parameters:
NSRC, 3, number of requesting units (index 0 = ALU, 1 = LSB, 2 = branch)
DEPTH, 2, entries per source queue (power of two, >= 2)
ROB_W, 4, ROB tag width (matches ROBBus)
DATA_W, 32, result/value width (matches DataBus)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global enable; 0 freezes all state except flush
flush_in  input  1  ROB mispredict clear
src_valid  input  NSRC  per-source result valid
src_rob  input  NSRC*ROB_W  packed ROB tags, source i at [i*ROB_W +: ROB_W]
src_value  input  NSRC*DATA_W  packed result values
src_aux  input  NSRC*DATA_W  packed auxiliary word (branch target pc / store addr), 0 if unused
src_ready  output  NSRC  per-source queue can accept
cdb_valid  output  1  broadcast valid (registered)
cdb_rob  output  ROB_W  broadcast ROB tag
cdb_value  output  DATA_W  broadcast value
cdb_aux  output  DATA_W  broadcast aux word
cdb_src  output  2  index of granted source

Behaviour:
- Reset (rst_in=0, async): all queues empty, rr_ptr=0, cdb_valid=0, cdb_rob=0, cdb_value=0, cdb_aux=0, cdb_src=0. src_ready then evaluates to all-ones.
- src_ready[i] = (count[i] != DEPTH), computed from registered state only. It does not depend on a same-cycle pop.
- Push: on a rising edge with rdy_in=1, flush_in=0, src_valid[i]=1 and src_ready[i]=1, write {rob,value,aux} at the tail of queue i.
- src_valid while not ready is a protocol violation. The data is dropped and the bench flags it.
- Grant (combinational, on registered queue state):
  - Scan sources starting at rr_ptr, wrapping modulo NSRC.
  - The first non-empty queue g wins.
- Rising edge with rdy_in=1, flush_in=0:
  - If a winner g exists: pop head of g; register cdb_valid=1, cdb_rob/value/aux=head fields, cdb_src=g; rr_ptr <= (g+1) mod NSRC.
  - If no winner: cdb_valid <= 0; cdb_rob/value/aux/src hold their previous values; rr_ptr unchanged.
- cdb_valid is a one-cycle pulse per entry. Each entry is broadcast exactly once. Order within a source is FIFO.
- Latency: result pushed at edge t is broadcast no earlier than the cycle after edge t+1, i.e. 2 cycles minimum with an idle bus.
- Simultaneous push and pop on the same queue is legal; count is unchanged.
  - A full queue being popped still reports src_ready=0 that cycle (conservative).
- Pointer and count widths: log2(DEPTH) head/tail pointers wrap naturally; count is log2(DEPTH)+1 bits.
- rdy_in=0: no push, no pop, rr_ptr and all outputs hold. cdb_valid holds its value; consumers qualify with rdy_in.
- flush_in=1 at an edge (regardless of rdy_in):
  - All queues are emptied and same-cycle pushes discarded.
  - cdb_valid <= 0 and rr_ptr <= 0.
  - A cdb_valid already high during the flush cycle is not re-issued.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Starvation bound: a non-empty queue is granted within NSRC grants.

Decomposition:
- Shared package/header (Definition.v): ROB_W/DATA_W macros and source index constants (SRC_ALU=0, SRC_LSB=1, SRC_BR=2).
- One natural sub-module, cdb_src_queue: a DEPTH-entry FIFO with push, pop, flush, full, empty, head, instantiated NSRC times via generate.
- The round-robin grant logic and the output register stay in cdb_arbiter.

Test Plan:
- Reset then single push ALU rob=3 value=0x11 aux=0 at edge 1 -> cdb_valid=1, rob=3, value=0x11, src=0 in cycle after edge 2; src_ready=3'b111 throughout.
- All three sources push every cycle (rob 1,2,3 first wave, then 4,5,6) -> grants in order src 0,1,2,0,1,2; every tag appears exactly once; src_ready drops to 0 when a queue holds 2 entries.
- ALU queue holds 2 entries, others empty -> broadcasts back-to-back in push order, rr_ptr ends at 1; pushing the ALU again while src_ready[0]=0 is flagged by the checker.
- Fill queues with 4 entries, assert flush_in one cycle while a new push is presented -> next cycle cdb_valid=0, all src_ready=1, flushed tags and the new push never appear on the CDB.
- rdy_in=0 for 5 cycles with entries pending and src_valid high -> no state change, no pushes accepted, cdb outputs frozen; after rdy_in=1, broadcasts resume in round-robin order with no loss or duplication.
- Assert rst_in low asynchronously between edges with entries pending -> all outputs 0 immediately, queues empty after release.
